uart_tx_fifo: RTL and testbench

//  Buffered, runtime-configurable UART transmitter; successor to the fixed 8N1 transmitter.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared types: parity selection and transmitter frame states.
// Latency: n/a (types only).
// Backpressure: n/a.
package uart_pkg;

    // Raw encoding 3 is not a member; receivers of the raw bits treat it as NONE.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered storage, read-first (head word visible combinationally).
// Latency: a pushed word is at the head one cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged before any same-cycle pop, so a full FIFO never accepts.
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign level_o   = cnt_q;

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, runtime divisor/parity/stop bits.
// Latency: word pushed into an empty FIFO while idle drives the start bit from the next edge.
// Backpressure: ready drops when the FIFO is full; frames run back-to-back while words remain.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      data,
    input  logic                   valid,
    output logic                   ready,
    input  logic [DIV_W-1:0]       baud_div,
    input  logic [1:0]             parity,
    input  logic                   stop2,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]  div_q, div_d;
    parity_t           par_q, par_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;

    logic              pop;
    logic              load;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic              bit_end;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (valid),
        .push_dat_i (data),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .full_o     (full),
        .empty_o    (empty),
        .level_o    (level)
    );

    assign ready   = ~full;
    assign tx      = tx_q;
    assign busy    = (state_q != IDLE) | (level != '0);
    // div_q already holds the clamped period (>= 2), so P-1 never underflows.
    assign bit_end = (cnt_q == (div_q - DIV_W'(1)));

    // Next-state: frame sequencing, shift/count updates and the registered line level.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == IDLE || bit_end) ? '0 : cnt_q + DIV_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        div_d     = div_q;
        par_d     = par_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                load = ~empty;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_BIT) begin
                        idx_d = '0;
                        if (par_q != PAR_NONE) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && idx_q == '0) begin
                        idx_d = IDX_W'(1);
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start: pop head and freeze this frame's configuration.
        if (load) begin
            state_d   = START;
            tx_d      = 1'b0;
            cnt_d     = '0;
            shift_d   = head;
            div_d     = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
            stop2_d   = stop2;
            case (parity)
                2'd1:    par_d = PAR_EVEN;
                2'd2:    par_d = PAR_ODD;
                default: par_d = PAR_NONE;
            endcase
            par_bit_d = (parity == 2'd2) ? ~^head : ^head;
        end
        pop = load;
    end

    // Frame state registers; reset returns the line to idle-high at once.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            div_q     <= DIV_W'(2);
            par_q     <= PAR_NONE;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            div_q     <= div_d;
            par_q     <= par_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic vs a waveform-level model.
// Latency: model predicts tx/level/ready/busy for every cycle.
// Backpressure: model accepts a push only when its queue was not full before the edge.
module tb_uart_tx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int DIV_W  = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] data = '0;
    logic              valid = 1'b0;
    logic              ready;
    logic [DIV_W-1:0]  baud_div = DIV_W'(4);
    logic [1:0]        parity = 2'd0;
    logic              stop2 = 1'b0;
    logic              tx;
    logic              busy;
    logic [LVL_W-1:0]  level;

    int checks = 0;
    int failures = 0;

    // Reference model: queued words and the line values of the frame in flight.
    logic [DATA_W-1:0] mq[$];
    bit                wq[$];
    bit                exp_tx = 1'b1;
    bit                exp_busy = 1'b0;

    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .baud_div (baud_div),
        .parity   (parity),
        .stop2    (stop2),
        .tx       (tx),
        .busy     (busy),
        .level    (level)
    );

    always #5 clock = ~clock;

    // Expand one word into its per-clock line levels.
    task automatic build_frame(input logic [DATA_W-1:0] w);
        int  p;
        bit  bits[$];
        p = (baud_div < 2) ? 2 : int'(baud_div);
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(w[i]);
        if (parity == 2'd1) bits.push_back(^w);
        if (parity == 2'd2) bits.push_back(~^w);
        bits.push_back(1'b1);
        if (stop2) bits.push_back(1'b1);
        foreach (bits[b]) for (int k = 0; k < p; k++) wq.push_back(bits[b]);
    endtask

    // One clock: advance the model with the inputs now applied, then compare mid-cycle.
    task automatic step();
        bit full_pre;
        bit in_frame;
        if (reset) begin
            mq.delete();
            wq.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            if (wq.size() == 0 && mq.size() > 0) build_frame(mq.pop_front());
            if (valid && !full_pre) mq.push_back(data);
            in_frame = (wq.size() > 0);
            exp_tx   = in_frame ? wq.pop_front() : 1'b1;
            exp_busy = in_frame || (mq.size() != 0);
        end
        @(posedge clock);
        @(negedge clock);
        checks += 4;
        if (tx !== exp_tx) begin
            failures++;
            $display("FAIL model_tx t=%0t got=%b exp=%b", $time, tx, exp_tx);
        end
        if (level !== LVL_W'(mq.size())) begin
            failures++;
            $display("FAIL model_level t=%0t got=%0d exp=%0d", $time, level, mq.size());
        end
        if (ready !== (mq.size() < DEPTH)) begin
            failures++;
            $display("FAIL model_ready t=%0t got=%b exp=%b", $time, ready, mq.size() < DEPTH);
        end
        if (busy !== exp_busy) begin
            failures++;
            $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, exp_busy);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() != 0 || wq.size() != 0 || exp_busy) && n < 5000) begin
            step();
            n++;
        end
        checks++;
        if (n >= 5000) begin
            failures++;
            $display("FAIL drain_timeout got=%0d exp=<5000", n);
        end
        step();
    endtask

    // Push one word and count busy samples until the line goes quiet; log tx samples.
    task automatic push_and_time(input logic [DATA_W-1:0] w, output int nbusy, output bit s[$]);
        nbusy = 0;
        s.delete();
        data  = w;
        valid = 1'b1;
        step();
        valid = 1'b0;
        while (busy === 1'b1 && nbusy < 400) begin
            s.push_back(tx);
            nbusy++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks += 4;
        if (tx !== 1'b1)     begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        if (ready !== 1'b1)  begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (level !== '0)    begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    endtask

    task automatic test_basic_frame();
        int n;
        bit s[$];
        bit ref_s[$];
        baud_div = 4; parity = 2'd0; stop2 = 1'b0;
        push_and_time(8'h55, n, s);
        checks++;
        if (n !== 41) begin failures++; $display("FAIL basic_busy_len got=%0d exp=41", n); end
        // s[0] is the push cycle; s[1..40] the frame.
        ref_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (s.size() < 41 || s[1 + 4*b + 2] !== ref_s[b]) begin
                failures++;
                $display("FAIL basic_bit%0d got=%b exp=%b", b, (s.size() >= 41) ? s[1+4*b+2] : 1'bx, ref_s[b]);
            end
        end
        step();
    endtask

    task automatic test_parity_stop2();
        int n;
        bit s[$];
        baud_div = 4; parity = 2'd1; stop2 = 1'b1;
        push_and_time(8'h07, n, s);
        checks += 2;
        if (n !== 49) begin failures++; $display("FAIL even_busy_len got=%0d exp=49", n); end
        if (s.size() < 49 || s[38] !== 1'b1) begin failures++; $display("FAIL even_parity_bit exp=1"); end
        parity = 2'd2;
        push_and_time(8'h07, n, s);
        checks += 2;
        if (n !== 49) begin failures++; $display("FAIL odd_busy_len got=%0d exp=49", n); end
        if (s.size() < 49 || s[38] !== 1'b0) begin failures++; $display("FAIL odd_parity_bit exp=0"); end
        step();
    endtask

    task automatic test_back_to_back();
        baud_div = 2; parity = 2'd0; stop2 = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            data = DATA_W'($urandom);
            step();
        end
        checks += 2;
        if (ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", ready); end
        if (level !== LVL_W'(DEPTH)) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", level, DEPTH); end
        for (int i = 0; i < 6; i++) begin
            data = DATA_W'($urandom);
            step();
        end
        valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_frame();
        baud_div = 4; parity = 2'd0; stop2 = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = DATA_W'($urandom);
            step();
        end
        valid = 1'b0;
        // First push edge was three steps back; bit 3 of data spans edges N+17..N+20.
        for (int i = 0; i < 16; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 4;
        if (tx !== 1'b1)    begin failures++; $display("FAIL midreset_tx got=%b exp=1", tx); end
        if (level !== '0)   begin failures++; $display("FAIL midreset_level got=%0d exp=0", level); end
        if (busy !== 1'b0)  begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        if (ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", ready); end
        data = 8'hA3; valid = 1'b1;
        step();
        valid = 1'b0;
        drain();
    endtask

    task automatic test_small_div_and_config();
        int n;
        bit s[$];
        parity = 2'd0; stop2 = 1'b0;
        baud_div = 0;
        push_and_time(8'h3C, n, s);
        checks++;
        if (n !== 21) begin failures++; $display("FAIL div0_busy_len got=%0d exp=21", n); end
        baud_div = 1;
        push_and_time(8'hC3, n, s);
        checks++;
        if (n !== 21) begin failures++; $display("FAIL div1_busy_len got=%0d exp=21", n); end
        baud_div = 3; parity = 2'd1; stop2 = 1'b0;
        valid = 1'b1; data = 8'h96; step();
        data = 8'h69; step();
        valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        baud_div = 5; parity = 2'd2; stop2 = 1'b1;
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            data  = DATA_W'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                baud_div = DIV_W'($urandom_range(0, 5));
                parity   = 2'($urandom_range(0, 3));
                stop2    = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 700) == 0) reset = 1'b1;
            step();
            reset = 1'b0;
        end
        valid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity_stop2();
        test_back_to_back();
        test_reset_mid_frame();
        test_small_div_and_config();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
